uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter DIV_W, default 16, width of the bit-period divisor.
REQ-003 SHALL have parameter DEPTH, default 4, receive FIFO entries (power of 2, >=2).
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port rxd  in  1  asynchronous serial line, idle high.
REQ-007 SHALL have port div  in  DIV_W  clocks per bit (legal >=4).
REQ-008 SHALL have port parity_en  in  1  parity bit present after data bits.
REQ-009 SHALL have port parity_odd  in  1  1 = odd parity, 0 = even.
REQ-010 SHALL have port two_stop  in  1  1 = two stop bits checked.
REQ-011 SHALL have port rd  in  1  pop head FIFO entry.
REQ-012 SHALL have port clr_ovr  in  1  clear sticky overrun.
REQ-013 SHALL have port rdy  out  1  FIFO not empty.
REQ-014 SHALL have port data  out  DATA_W  head entry data, LSB = first received bit.
REQ-015 SHALL have port frame_err  out  1  head entry stop-bit error.
REQ-016 SHALL have port par_err  out  1  head entry parity error (0 when parity_en was 0).
REQ-017 SHALL have port overrun  out  1  sticky: a frame was dropped on full FIFO.
REQ-018 SHALL have port count  out  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-019 rxd SHALL pass through a 2-flop synchronizer (both flops set to 1); only the second-flop value (line) is used.
REQ-020 FSM states SHALL be IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-021 In IDLE a 1->0 transition of line SHALL enter START, clear the tick counter and latch div, parity_en, parity_odd, two_stop; later input changes SHALL NOT affect the frame in progress.
REQ-022 Tick counter SHALL count 0..div-1 then wrap to 0 (bit end); mid-bit sample point is tick == div>>1 (floor).
REQ-023 START: line sampled 1 at mid-bit SHALL return to IDLE (glitch rejection, nothing pushed); sampled 0 continues; bit end enters DATA.
REQ-024 DATA: line SHALL be sampled at mid-bit and shifted in LSB first; after DATA_W bit ends go to PARITY if parity_en, else STOP1.
REQ-025 PARITY: par_err = XOR(data bits, parity bit) XOR parity_odd, i.e. even parity expects XOR = 0, odd expects 1.
REQ-026 STOP1: frame_err SHALL be set if line samples 0 at mid-bit; if two_stop=0 the frame SHALL be pushed at that mid-bit cycle and the FSM SHALL return to IDLE in the same cycle (no wait for bit end).
REQ-027 STOP2 (two_stop=1): STOP1 bit end enters STOP2; frame_err SHALL be OR-ed with a 0 sample at STOP2 mid-bit; push and return to IDLE occur there.
REQ-028 Frames with frame_err or par_err SHALL still be pushed, with flags stored alongside data.
REQ-029 FIFO SHALL be first-word-fall-through: data/frame_err/par_err reflect the head entry whenever rdy=1; values are don't-care when rdy=0.
REQ-030 rdy SHALL rise the cycle after the push edge; rd with rdy=0 SHALL be ignored.
REQ-031 Push with FIFO full and no simultaneous accepted pop SHALL drop the frame and set overrun; push and pop in the same cycle when full SHALL accept the frame, count unchanged.
REQ-032 Simultaneous push and pop at any occupancy SHALL leave count unchanged and preserve order.
REQ-033 overrun SHALL clear on clr_ovr; a drop in the same cycle as clr_ovr SHALL leave overrun=1.
REQ-034 Read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH.

Reset
REQ-035 rst SHALL force FSM to IDLE, tick/bit counters and shift register to 0, synchronizer flops to 1, FIFO empty (count=0, rdy=0), overrun=0, frame_err=0, par_err=0, data=0.
REQ-036 rst during a frame SHALL abort it without a push; a frame whose start edge follows rst deassertion SHALL be received normally.

Verification
REQ-037 div=8, 8N1, send 0xA5 -> exactly one push, data=0xA5, frame_err=0, par_err=0, rdy 1 cycle after STOP1 mid-sample.
REQ-038 div=8, parity_en=1, parity_odd=0, send 0x03 with parity bit 1 -> par_err=1, data=0x03; same with parity bit 0 -> par_err=0.
REQ-039 rxd low pulse of 3 clocks with div=8 -> no push, FSM back to IDLE, count=0.
REQ-040 two_stop=1, second stop bit driven 0 -> frame_err=1; first stop 1 and second 1 -> frame_err=0.
REQ-041 DEPTH=4, send 5 frames 0x10..0x14 without rd -> count=4, overrun=1, reads return 0x10..0x13; clr_ovr clears overrun.
REQ-042 Assert rst mid-DATA of frame 0x55, then send 0x66 -> only 0x66 appears in FIFO.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver with a 2-flop line synchronizer, start-glitch rejection, optional parity and
// one/two stop bits, feeding a first-word-fall-through FIFO with per-entry error flags.
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rxd,
    input  logic [DIV_W-1:0]         div,
    input  logic                     parity_en,
    input  logic                     parity_odd,
    input  logic                     two_stop,
    input  logic                     rd,
    input  logic                     clr_ovr,
    output logic                     rdy,
    output logic [DATA_W-1:0]        data,
    output logic                     frame_err,
    output logic                     par_err,
    output logic                     overrun,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(DATA_W);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP1  = 3'd4;
    localparam logic [2:0] S_STOP2  = 3'd5;

    localparam logic [AW:0]       FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [BW-1:0]     LAST_BIT = BW'(DATA_W - 1);
    localparam logic [DIV_W-1:0]  ONE_D    = DIV_W'(1);

    logic              r_sync1, r_sync2, r_lineD;
    logic [2:0]        r_state;
    logic [DIV_W-1:0]  r_tick, r_div;
    logic [BW-1:0]     r_bitCnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_parEn, r_parOdd, r_twoStop, r_parErr, r_frameErr;

    logic [DATA_W-1:0] r_memData [DEPTH];
    logic              r_memFe   [DEPTH];
    logic              r_memPe   [DEPTH];
    logic [AW-1:0]     r_wptr, r_rptr;
    logic [AW:0]       r_count;
    logic              r_overrun;

    logic w_line, w_mid, w_bitEnd;
    logic w_push, w_pushFe, w_pop, w_full, w_accept, w_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_lineD <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
            r_lineD <= r_sync2;
        end
    end

    assign w_line   = r_sync2;
    assign w_mid    = (r_tick == (r_div >> 1));
    assign w_bitEnd = (r_tick == r_div - ONE_D);

    // Frame settings are captured at the start edge so the whole frame uses one configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tick     <= '0;
            r_div      <= '0;
            r_bitCnt   <= '0;
            r_shift    <= '0;
            r_parEn    <= 1'b0;
            r_parOdd   <= 1'b0;
            r_twoStop  <= 1'b0;
            r_parErr   <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            if (r_state != S_IDLE) begin
                r_tick <= w_bitEnd ? '0 : r_tick + ONE_D;
            end
            case (r_state)
                S_IDLE: begin
                    if (r_lineD && !w_line) begin
                        r_state    <= S_START;
                        r_tick     <= '0;
                        r_bitCnt   <= '0;
                        r_div      <= div;
                        r_parEn    <= parity_en;
                        r_parOdd   <= parity_odd;
                        r_twoStop  <= two_stop;
                        r_parErr   <= 1'b0;
                        r_frameErr <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_mid && w_line) begin
                        r_state <= S_IDLE;
                    end else if (w_bitEnd) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_mid) begin
                        r_shift <= {w_line, r_shift[DATA_W-1:1]};
                    end
                    if (w_bitEnd) begin
                        if (r_bitCnt == LAST_BIT) begin
                            r_bitCnt <= '0;
                            r_state  <= r_parEn ? S_PARITY : S_STOP1;
                        end else begin
                            r_bitCnt <= r_bitCnt + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_mid) begin
                        r_parErr <= (^r_shift) ^ w_line ^ r_parOdd;
                    end
                    if (w_bitEnd) begin
                        r_state <= S_STOP1;
                    end
                end
                S_STOP1: begin
                    if (w_mid) begin
                        r_frameErr <= ~w_line;
                        if (!r_twoStop) begin
                            r_state <= S_IDLE;
                        end
                    end else if (w_bitEnd) begin
                        r_state <= S_STOP2;
                    end
                end
                S_STOP2: begin
                    if (w_mid) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The frame is pushed on the last stop-bit mid-sample, not at its bit end.
    always_comb begin
        w_push   = 1'b0;
        w_pushFe = 1'b0;
        if (r_state == S_STOP1 && w_mid && !r_twoStop) begin
            w_push   = 1'b1;
            w_pushFe = ~w_line;
        end else if (r_state == S_STOP2 && w_mid) begin
            w_push   = 1'b1;
            w_pushFe = r_frameErr | ~w_line;
        end
    end

    assign w_pop    = rd && (r_count != '0);
    assign w_full   = (r_count == FULL_CNT);
    assign w_accept = w_push && (!w_full || w_pop);
    assign w_drop   = w_push && !w_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_memData[i] <= '0;
                r_memFe[i]   <= 1'b0;
                r_memPe[i]   <= 1'b0;
            end
        end else begin
            if (w_accept) begin
                r_memData[r_wptr] <= r_shift;
                r_memFe[r_wptr]   <= w_pushFe;
                r_memPe[r_wptr]   <= r_parErr;
                r_wptr            <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_accept && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            // A drop wins over a same-cycle clear so the loss is never hidden.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_ovr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign rdy       = (r_count != '0);
    assign data      = r_memData[r_rptr];
    assign frame_err = r_memFe[r_rptr];
    assign par_err   = r_memPe[r_rptr];
    assign overrun   = r_overrun;
    assign count     = r_count;

endmodule
